io_responder: RTL

Peripheral-side responder for the processor's IN/OUT instructions. It debounces the Enter key, captures the switch word for IN, and converts the OUT operand to eight seven-segment digits. Each request is answered with a one-cycle acknowledge that lets the PC advance. It sits between the core's I/O control signals and the board keys, switches and displays.

---
 rtl/io_resp_pkg.sv | 40 ++++
 rtl/io_debounce.sv | 48 ++++
 rtl/io_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/io_resp_pkg.sv
// Shared types and seven-segment helpers for the IN/OUT responder.
// Segment encoding is active-low, bit 0 = segment a .. bit 6 = segment g.
package io_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_WAIT_RELEASE,
        ST_IN_DONE,
        ST_OUT_CONV,
        ST_OUT_DONE
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    function automatic logic [6:0] nib2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Key debouncer: 2-FF synchronizer plus stability counter; one-cycle press/release pulses.
// Edges lag the raw key by 2 + DEBOUNCE_CYCLES cycles; no backpressure, pulses are fire-and-forget.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic key_n_i,
    output logic press_o,
    output logic release_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync2_q, level_q, press_q, release_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            // Any sample matching the accepted level restarts the stability window.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q     <= '0;
                level_q   <= sync2_q;
                press_q   <= ~sync2_q;
                release_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/io_responder.sv
// IN/OUT responder: key-gated switch capture for IN, 8-digit display for OUT; one-cycle acks, core holds request until ack.
// OUT ack at N+1 (hex) or N+34 (decimal, IO_RESP_DECIMAL_EN defined: signed double-dabble with blanking).
module io_responder
    import io_resp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SW_WIDTH        = 10
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                in_req,
    input  logic                out_req,
    input  logic [31:0]         out_data,
    input  logic                enter_n,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [31:0]         in_data,
    output logic                in_ack,
    output logic                out_ack,
    output logic                busy,
    output logic [6:0]          hex0,
    output logic [6:0]          hex1,
    output logic [6:0]          hex2,
    output logic [6:0]          hex3,
    output logic [6:0]          hex4,
    output logic [6:0]          hex5,
    output logic [6:0]          hex6,
    output logic [6:0]          hex7
);

    state_e          state_q;
    logic [31:0]     data_q, in_data_q;
    logic            in_ack_q, out_ack_q;
    logic [7:0][6:0] hex_q, seg_d;
    logic            key_press, key_release;

    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk_i    (CLK),
        .rst_n_i  (reset),
        .key_n_i  (enter_n),
        .press_o  (key_press),
        .release_o(key_release)
    );

`ifdef IO_RESP_DECIMAL_EN
    logic [31:0] bcd_q, bcd_adj;
    logic        neg_q, lead;
    logic [5:0]  bit_cnt_q;
    logic [3:0]  dig;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // hex7 carries the sign when negative, so blanking scans from hex6 down in that case.
    always_comb begin
        seg_d = {8{SEG_BLANK}};
        lead  = 1'b1;
        dig   = '0;
        for (int i = 7; i >= 0; i--) begin
            dig = bcd_q[i*4 +: 4];
            if (i == 7 && neg_q) begin
                seg_d[i] = SEG_MINUS;
            end else if (lead && dig == 4'd0 && i != 0) begin
                seg_d[i] = SEG_BLANK;
            end else begin
                seg_d[i] = nib2seg(dig);
                lead     = 1'b0;
            end
        end
    end
`else
    always_comb begin
        seg_d = {8{SEG_BLANK}};
        for (int i = 0; i < 8; i++) seg_d[i] = nib2seg(data_q[i*4 +: 4]);
    end
`endif

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            in_data_q <= '0;
            in_ack_q  <= 1'b0;
            out_ack_q <= 1'b0;
            hex_q     <= {8{SEG_BLANK}};
`ifdef IO_RESP_DECIMAL_EN
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            bit_cnt_q <= '0;
`endif
        end else begin
            in_ack_q  <= 1'b0;
            out_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (out_req) begin
                        data_q <= out_data;
`ifdef IO_RESP_DECIMAL_EN
                        bit_cnt_q <= '0;
                        state_q   <= ST_OUT_CONV;
`else
                        state_q   <= ST_OUT_DONE;
`endif
                    end else if (in_req) begin
                        state_q <= ST_WAIT_PRESS;
                    end
                end
                ST_WAIT_PRESS: begin
                    if (key_press) begin
                        in_data_q <= 32'(sw);
                        state_q   <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (key_release) begin
                        in_ack_q <= 1'b1;
                        state_q  <= ST_IN_DONE;
                    end
                end
                ST_IN_DONE: state_q <= ST_IDLE;
`ifdef IO_RESP_DECIMAL_EN
                ST_OUT_CONV: begin
                    // Count 0 is the setup cycle; counts 1..32 each shift one magnitude bit in.
                    if (bit_cnt_q == 6'd0) begin
                        neg_q     <= data_q[31];
                        data_q    <= data_q[31] ? (~data_q + 32'd1) : data_q;
                        bcd_q     <= '0;
                        bit_cnt_q <= 6'd1;
                    end else begin
                        bcd_q     <= {bcd_adj[30:0], data_q[31]};
                        data_q    <= {data_q[30:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd32) state_q <= ST_OUT_DONE;
                    end
                end
`endif
                ST_OUT_DONE: begin
                    hex_q     <= seg_d;
                    out_ack_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_data = in_data_q;
    assign in_ack  = in_ack_q;
    assign out_ack = out_ack_q;
    assign busy    = (state_q != ST_IDLE);
    assign hex0    = hex_q[0];
    assign hex1    = hex_q[1];
    assign hex2    = hex_q[2];
    assign hex3    = hex_q[3];
    assign hex4    = hex_q[4];
    assign hex5    = hex_q[5];
    assign hex6    = hex_q[6];
    assign hex7    = hex_q[7];

endmodule
